// File: rtl/scenario_sequencer.sv
// Sequences the scenario multiplexer through a programmed table of
// (scenario code, repeat count) entries, pulsing start/clear and
// enforcing a per-run completion timeout.
module scenario_sequencer #(
    parameter int unsigned          DEPTH      = 8,
    parameter int unsigned          CODE_W     = 3,
    parameter int unsigned          REP_W      = 8,
    parameter int unsigned          STATE_W    = 8,
    parameter logic [STATE_W-1:0]   DONE_STATE = {STATE_W{1'b1}},
    parameter int unsigned          TIMEOUT    = 1000000,
    parameter int unsigned          GAP_CYCLES = 16,
    localparam int unsigned         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clock_reg_input,
    input  logic                    reset_reg_input,
    input  logic                    wr_en_reg_input,
    input  logic [AW-1:0]           wr_addr_reg_input,
    input  logic [CODE_W+REP_W-1:0] wr_data_reg_input,
    input  logic [AW:0]             num_entries_reg_input,
    input  logic                    start_reg_input,
    input  logic                    abort_reg_input,
    input  logic [STATE_W-1:0]      scenario_state_reg_input,
    output logic [CODE_W-1:0]       scenario_select_reg_output,
    output logic                    scenario_start_reg_output,
    output logic                    scenario_clear_reg_output,
    output logic                    busy_reg_output,
    output logic                    done_reg_output,
    output logic                    error_reg_output,
    output logic [AW-1:0]           index_reg_output,
    output logic [REP_W-1:0]        run_count_reg_output
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [AW:0]   NumMax    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastMax   = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GapLast   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StArm,
        StWait,
        StSettle,
        StNext,
        StFinish,
        StFault
    } state_e;

    state_e              state_q;
    logic [CODE_W-1:0]   code_mem [DEPTH];
    logic [REP_W-1:0]    rep_mem  [DEPTH];

    logic [AW-1:0]       index_q;
    logic [AW-1:0]       last_q;
    logic [REP_W-1:0]    rep_q;
    logic [REP_W-1:0]    run_count_q;
    logic [TW-1:0]       timer_q;
    logic [GW-1:0]       gap_q;
    logic [CODE_W-1:0]   select_q;
    logic                start_q;
    logic                clear_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic                idle_like;
    logic                in_run;
    logic [REP_W-1:0]    rd_rep;
    logic [REP_W-1:0]    rep_eff;
    logic [REP_W-1:0]    run_next;

    // Decode helpers for the current state and the entry being loaded.
    always_comb begin
        idle_like = (state_q == StIdle) || (state_q == StFault);
        in_run    = (state_q == StLoad) || (state_q == StArm) || (state_q == StWait) ||
                    (state_q == StSettle) || (state_q == StNext);
        rd_rep    = rep_mem[index_q];
        // A zero repeat count still runs the scenario once.
        rep_eff   = (rd_rep == '0) ? REP_W'(1) : rd_rep;
        run_next  = run_count_q + 1'b1;
    end

    // Program table; never reset so a program survives a reset.
    always_ff @(posedge clock_reg_input) begin
        if (wr_en_reg_input && idle_like) begin
            code_mem[wr_addr_reg_input] <= wr_data_reg_input[CODE_W+REP_W-1:REP_W];
            rep_mem[wr_addr_reg_input]  <= wr_data_reg_input[REP_W-1:0];
        end
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clock_reg_input) begin
        if (!reset_reg_input) begin
            state_q     <= StIdle;
            index_q     <= '0;
            last_q      <= '0;
            rep_q       <= '0;
            run_count_q <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            select_q    <= '0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort_reg_input && in_run) begin
                // Abort wins over any transition due this cycle.
                clear_q  <= 1'b1;
                select_q <= '0;
                busy_q   <= 1'b0;
                state_q  <= StIdle;
            end else begin
                case (state_q)
                    StIdle, StFault: begin
                        if (start_reg_input) begin
                            error_q <= 1'b0;
                            if (num_entries_reg_input == '0) begin
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                index_q <= '0;
                                if (num_entries_reg_input > NumMax) begin
                                    last_q <= LastMax;
                                end else begin
                                    last_q <= AW'(num_entries_reg_input - 1'b1);
                                end
                                busy_q  <= 1'b1;
                                state_q <= StLoad;
                            end
                        end
                    end
                    StLoad: begin
                        select_q    <= code_mem[index_q];
                        rep_q       <= rep_eff;
                        run_count_q <= '0;
                        start_q     <= 1'b1;
                        state_q     <= StArm;
                    end
                    StArm: begin
                        timer_q <= '0;
                        state_q <= StWait;
                    end
                    StWait: begin
                        // Completion takes priority over a coincident timeout.
                        if (scenario_state_reg_input == DONE_STATE) begin
                            clear_q <= 1'b1;
                            gap_q   <= '0;
                            state_q <= StSettle;
                        end else if (timer_q == TimerLast) begin
                            error_q  <= 1'b1;
                            clear_q  <= 1'b1;
                            select_q <= '0;
                            busy_q   <= 1'b0;
                            state_q  <= StFault;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    StSettle: begin
                        if (gap_q == GapLast) begin
                            run_count_q <= run_next;
                            if (run_next < rep_q) begin
                                start_q <= 1'b1;
                                state_q <= StArm;
                            end else begin
                                state_q <= StNext;
                            end
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    StNext: begin
                        if (index_q == last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFinish;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= StLoad;
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign scenario_select_reg_output = select_q;
    assign scenario_start_reg_output  = start_q;
    assign scenario_clear_reg_output  = clear_q;
    assign busy_reg_output            = busy_q;
    assign done_reg_output            = done_q;
    assign error_reg_output           = error_q;
    assign index_reg_output           = index_q;
    assign run_count_reg_output       = run_count_q;

endmodule

// File: tb/tb_scenario_sequencer.sv
// Bench for scenario_sequencer: a responder emulates the multiplexer and a
// timeline model predicts every start/clear/done event of a programmed run.
module tb_scenario_sequencer;

    localparam int DEPTH   = 8;
    localparam int CODE_W  = 3;
    localparam int REP_W   = 8;
    localparam int STATE_W = 8;
    localparam int TIMEOUT = 50;
    localparam int GAP     = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    wr_en;
    logic [2:0]              wr_addr;
    logic [CODE_W+REP_W-1:0] wr_data;
    logic [3:0]              num_entries;
    logic                    start;
    logic                    abort;
    logic [STATE_W-1:0]      sstate;
    logic [CODE_W-1:0]       sel;
    logic                    sstart;
    logic                    sclear;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [2:0]              index;
    logic [REP_W-1:0]        run_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int m_code [DEPTH];
    int m_rep  [DEPTH];
    int plan[$];
    int resp_delay[$];
    int resp_cnt;
    bit resp_active;

    int mon_start_cyc[$];
    int mon_start_sel[$];
    int mon_start_rc[$];
    int mon_start_idx[$];
    int mon_clear_cyc[$];
    int mon_done_cyc[$];

    scenario_sequencer #(
        .DEPTH      (DEPTH),
        .CODE_W     (CODE_W),
        .REP_W      (REP_W),
        .STATE_W    (STATE_W),
        .DONE_STATE (8'hFF),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock_reg_input            (clk),
        .reset_reg_input            (rst_n),
        .wr_en_reg_input            (wr_en),
        .wr_addr_reg_input          (wr_addr),
        .wr_data_reg_input          (wr_data),
        .num_entries_reg_input      (num_entries),
        .start_reg_input            (start),
        .abort_reg_input            (abort),
        .scenario_state_reg_input   (sstate),
        .scenario_select_reg_output (sel),
        .scenario_start_reg_output  (sstart),
        .scenario_clear_reg_output  (sclear),
        .busy_reg_output            (busy),
        .done_reg_output            (done),
        .error_reg_output           (error),
        .index_reg_output           (index),
        .run_count_reg_output       (run_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor.
    always @(negedge clk) begin
        if (sstart) begin
            mon_start_cyc.push_back(cyc);
            mon_start_sel.push_back(int'(sel));
            mon_start_rc.push_back(int'(run_count));
            mon_start_idx.push_back(int'(index));
        end
        if (sclear) mon_clear_cyc.push_back(cyc);
        if (done) mon_done_cyc.push_back(cyc);
    end

    // Multiplexer emulation: reports DONE a planned number of cycles after each
    // start (0 = never), noise otherwise, and returns to 0 on clear.
    always @(negedge clk) begin
        if (!rst_n || sclear) begin
            sstate      = '0;
            resp_active = 1'b0;
        end else if (sstart) begin
            resp_cnt    = (resp_delay.size() > 0) ? resp_delay.pop_front() : 3;
            resp_active = (resp_cnt > 0);
            sstate      = 8'($urandom_range(0, 254));
        end else if (resp_active) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                sstate      = 8'hFF;
                resp_active = 1'b0;
            end else begin
                sstate = 8'($urandom_range(0, 254));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_start_cyc.delete();
        mon_start_sel.delete();
        mon_start_rc.delete();
        mon_start_idx.delete();
        mon_clear_cyc.delete();
        mon_done_cyc.delete();
    endtask

    task automatic write_entry(input int addr, input int code, input int rep);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = {CODE_W'(code), REP_W'(rep)};
        tick();
        wr_en   = 1'b0;
        m_code[addr] = code;
        m_rep[addr]  = rep;
    endtask

    // Start the program with n entries, predict its timeline from the table
    // and `plan`, then compare every observed event and the final outputs.
    task automatic run_program(input string name, input int n);
        int e_cyc[$];
        int e_sel[$];
        int e_rc[$];
        int e_idx[$];
        int e_clr[$];
        int exp_done;
        int t;
        int k;
        int d;
        int r;
        int nn;
        int s;
        int r_last;
        bit exp_fault;
        bit finished;
        nn = (n > DEPTH) ? DEPTH : n;
        t = 2;
        k = 0;
        exp_done = -1;
        exp_fault = 1'b0;
        r_last = 0;
        finished = 1'b0;
        if (nn == 0) exp_done = 1;
        for (int e = 0; e < nn && !exp_fault; e++) begin
            r = (m_rep[e] == 0) ? 1 : m_rep[e];
            r_last = r;
            for (int j = 0; j < r; j++) begin
                e_cyc.push_back(t);
                e_sel.push_back(m_code[e]);
                e_rc.push_back(j);
                e_idx.push_back(e);
                d = (k < plan.size()) ? plan[k] : 3;
                k++;
                if (d == 0) begin
                    e_clr.push_back(t + TIMEOUT + 1);
                    exp_fault = 1'b1;
                    break;
                end
                e_clr.push_back(t + d + 1);
                if (j < r - 1) t += d + GAP + 1;
                else if (e < nn - 1) t += d + GAP + 3;
                else exp_done = t + d + GAP + 2;
            end
        end

        clear_mon();
        resp_delay = plan;
        num_entries = 4'(n);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== (nn > 0)) begin
            failures++;
            $display("FAIL %s busy_after_start: got %0b expected %0b", name, busy, nn > 0);
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL %s error_cleared: got %0b expected 0", name, error);
        end
        for (int i = 0; i < 20000; i++) begin
            if (mon_done_cyc.size() > 0 || error === 1'b1) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s completion: got none expected done or fault", name);
        end
        repeat (GAP + 6) tick();

        checks++;
        if (mon_start_cyc.size() != e_cyc.size()) begin
            failures++;
            $display("FAIL %s start_count: got %0d expected %0d", name,
                     mon_start_cyc.size(), e_cyc.size());
        end
        for (int i = 0; i < e_cyc.size() && i < mon_start_cyc.size(); i++) begin
            checks++;
            if (mon_start_cyc[i] - s != e_cyc[i] || mon_start_sel[i] != e_sel[i] ||
                mon_start_rc[i] != e_rc[i] || mon_start_idx[i] != e_idx[i]) begin
                failures++;
                $display("FAIL %s start[%0d]: got cyc=%0d sel=%0d rc=%0d idx=%0d expected cyc=%0d sel=%0d rc=%0d idx=%0d",
                         name, i, mon_start_cyc[i] - s, mon_start_sel[i], mon_start_rc[i],
                         mon_start_idx[i], e_cyc[i], e_sel[i], e_rc[i], e_idx[i]);
            end
        end
        checks++;
        if (mon_clear_cyc.size() != e_clr.size()) begin
            failures++;
            $display("FAIL %s clear_count: got %0d expected %0d", name,
                     mon_clear_cyc.size(), e_clr.size());
        end
        for (int i = 0; i < e_clr.size() && i < mon_clear_cyc.size(); i++) begin
            checks++;
            if (mon_clear_cyc[i] - s != e_clr[i]) begin
                failures++;
                $display("FAIL %s clear[%0d]: got cyc=%0d expected cyc=%0d", name, i,
                         mon_clear_cyc[i] - s, e_clr[i]);
            end
        end
        checks++;
        if (exp_done < 0) begin
            if (mon_done_cyc.size() != 0) begin
                failures++;
                $display("FAIL %s done_count: got %0d expected 0", name, mon_done_cyc.size());
            end
        end else if (mon_done_cyc.size() != 1 || mon_done_cyc[0] - s != exp_done) begin
            failures++;
            $display("FAIL %s done: got count=%0d first_cyc=%0d expected count=1 cyc=%0d", name,
                     mon_done_cyc.size(),
                     (mon_done_cyc.size() > 0) ? mon_done_cyc[0] - s : -1, exp_done);
        end
        checks++;
        if (error !== exp_fault) begin
            failures++;
            $display("FAIL %s error_final: got %0b expected %0b", name, error, exp_fault);
        end
        if (exp_fault) begin
            checks++;
            if (sel !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s fault_outputs: got sel=%0d busy=%0b expected sel=0 busy=0",
                         name, sel, busy);
            end
        end else if (nn > 0) begin
            checks++;
            if (int'(index) != nn - 1 || int'(run_count) != r_last ||
                int'(sel) != m_code[nn - 1] || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s final_outputs: got idx=%0d rc=%0d sel=%0d busy=%0b expected idx=%0d rc=%0d sel=%0d busy=0",
                         name, index, run_count, sel, busy, nn - 1, r_last, m_code[nn - 1]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (sel !== '0 || sstart !== 1'b0 || sclear !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || index !== '0 || run_count !== '0) begin
            failures++;
            $display("FAIL %s outputs: got sel=%0d st=%0b clr=%0b busy=%0b done=%0b err=%0b idx=%0d rc=%0d expected all 0",
                     name, sel, sstart, sclear, busy, done, error, index, run_count);
        end
    endtask

    task automatic wait_events(input int n_starts, input int n_clears, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (mon_start_cyc.size() >= n_starts && mon_clear_cyc.size() >= n_clears) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s wait: got starts=%0d clears=%0d expected %0d/%0d", name,
                     mon_start_cyc.size(), mon_clear_cyc.size(), n_starts, n_clears);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_entries();
        plan.delete();
        run_program("zero_entries", 0);
    endtask

    task automatic test_single();
        write_entry(0, 2, 1);
        plan = '{5};
        run_program("single", 1);
    endtask

    task automatic test_multi();
        write_entry(0, 1, 3);
        write_entry(1, 3, 2);
        plan = '{2, 7, 4, 1, 8};
        run_program("multi", 2);
    endtask

    task automatic test_timeout();
        write_entry(0, 5, 2);
        plan = '{0};
        run_program("timeout", 1);
        // Table stays writable while faulted; the rerun must use the new entry.
        write_entry(0, 7, 2);
        plan = '{3, 3};
        run_program("timeout_rerun", 1);
    endtask

    task automatic test_abort();
        int b;
        write_entry(0, 4, 3);
        clear_mon();
        resp_delay = '{4, 30, 30};
        num_entries = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_events(2, 0, "abort");
        repeat (2) tick();
        abort = 1'b1;
        b = cyc;
        tick();
        abort = 1'b0;
        checks++;
        if (sclear !== 1'b1 || sel !== '0 || busy !== 1'b0 || done !== 1'b0 || cyc != b + 1) begin
            failures++;
            $display("FAIL abort_outputs: got clr=%0b sel=%0d busy=%0b done=%0b expected clr=1 sel=0 busy=0 done=0",
                     sclear, sel, busy, done);
        end
        repeat (8) tick();
        checks++;
        if (mon_done_cyc.size() != 0 || mon_start_cyc.size() != 2) begin
            failures++;
            $display("FAIL abort_quiet: got done=%0d starts=%0d expected done=0 starts=2",
                     mon_done_cyc.size(), mon_start_cyc.size());
        end
        write_entry(0, 6, 1);
        plan = '{2};
        run_program("abort_then_write", 1);
    endtask

    task automatic test_reset_mid_settle();
        write_entry(0, 3, 2);
        write_entry(1, 6, 1);
        clear_mon();
        resp_delay = '{4, 4, 4};
        num_entries = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_events(1, 1, "reset_settle");
        rst_n = 1'b0;
        tick();
        check_all_zero("reset_mid_settle");
        tick();
        rst_n = 1'b1;
        tick();
        plan = '{4, 5, 2};
        run_program("rerun_after_reset", 2);
    endtask

    task automatic test_busy_write();
        write_entry(0, 1, 1);
        write_entry(1, 2, 1);
        clear_mon();
        resp_delay = '{20, 20};
        num_entries = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Busy now: this write must be dropped, so the model is not updated.
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = {3'd4, 8'd3};
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 2000 && mon_done_cyc.size() == 0; i++) tick();
        tick();
        plan = '{3, 3};
        run_program("busy_write", 2);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_entry(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end
            plan.delete();
            repeat (40) plan.push_back(int'($urandom_range(1, 8)));
            n = (it == 0) ? 12 : int'($urandom_range(1, DEPTH));
            run_program($sformatf("random%0d", it), n);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        num_entries = '0;
        start       = 1'b0;
        abort       = 1'b0;
        sstate      = '0;
        resp_active = 1'b0;
        resp_cnt    = 0;
        for (int a = 0; a < DEPTH; a++) begin
            m_code[a] = 0;
            m_rep[a]  = 0;
        end
        test_reset();
        test_zero_entries();
        test_single();
        test_multi();
        test_timeout();
        test_abort();
        test_reset_mid_settle();
        test_busy_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
